// File: rtl/game_pkg.sv
// Shared state codes, question ROM and BCD/LFSR helpers for the factorization game.
package game_pkg;

    localparam logic [3:0] CODE_IDLE    = 4'd0;
    localparam logic [3:0] CODE_LOAD    = 4'd1;
    localparam logic [3:0] CODE_INPUT   = 4'd2;
    localparam logic [3:0] CODE_JUDGE   = 4'd3;
    localparam logic [3:0] CODE_CORRECT = 4'd4;
    localparam logic [3:0] CODE_WRONG   = 4'd5;
    localparam logic [3:0] CODE_TIMEOUT = 4'd6;
    localparam logic [3:0] CODE_FINISH  = 4'd7;

    typedef enum logic [3:0] {
        ST_IDLE    = CODE_IDLE,
        ST_LOAD    = CODE_LOAD,
        ST_INPUT   = CODE_INPUT,
        ST_JUDGE   = CODE_JUDGE,
        ST_CORRECT = CODE_CORRECT,
        ST_WRONG   = CODE_WRONG,
        ST_TIMEOUT = CODE_TIMEOUT,
        ST_FINISH  = CODE_FINISH
    } state_t;

    // Every entry is a product of two primes; index 0 is never produced by the LFSR.
    function automatic logic [23:0] q_rom(input logic [3:0] idx);
        case (idx)
            4'd1:    q_rom = 24'h000221;
            4'd2:    q_rom = 24'h000323;
            4'd3:    q_rom = 24'h000143;
            4'd4:    q_rom = 24'h000437;
            4'd5:    q_rom = 24'h000899;
            4'd6:    q_rom = 24'h001147;
            4'd7:    q_rom = 24'h001517;
            4'd8:    q_rom = 24'h001763;
            4'd9:    q_rom = 24'h000667;
            4'd10:   q_rom = 24'h002021;
            4'd11:   q_rom = 24'h002491;
            4'd12:   q_rom = 24'h003127;
            4'd13:   q_rom = 24'h003599;
            4'd14:   q_rom = 24'h004087;
            4'd15:   q_rom = 24'h004757;
            default: q_rom = 24'h000000;
        endcase
    endfunction

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        lfsr_next = {q[2:0], q[3] ^ q[2]};
    endfunction

    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] d);
        bcd_inc_sat = (d >= 4'd9) ? 4'd9 : d + 4'd1;
    endfunction

    // Two-digit BCD decrement that holds at 00.
    function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
        if (v == 8'h00)
            bcd_dec2 = 8'h00;
        else if (v[3:0] == 4'd0)
            bcd_dec2 = {v[7:4] - 4'd1, 4'd9};
        else
            bcd_dec2 = {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown with synchronous load and per-tick decrement.
module bcd_down_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       tick,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero
);
    import game_pkg::*;

    logic [7:0] count;
    logic [7:0] count_dec;

    assign count_dec = bcd_dec2(count);

    always_ff @(posedge clk) begin
        if (rst)
            count <= 8'h00;
        else if (load)
            count <= {load_tens, load_ones};
        else if (tick)
            count <= count_dec;
    end

    assign tens = count[7:4];
    assign ones = count[3:0];
    // Flags the tick that lands on 00 so the caller can react in that same cycle.
    assign zero = tick && (count != 8'h00) && (count_dec == 8'h00);

endmodule

// File: rtl/game_sequencer.sv
// Game controller: picks questions, runs the per-question timer, judges answers and keeps score.
module game_sequencer #(
    parameter int         TICK_DIV    = 50000000,
    parameter int         TIME_LIMIT  = 30,
    parameter int         RESULT_HOLD = 100000000,
    parameter int         NUM_Q       = 5,
    parameter logic [3:0] LFSR_SEED   = 4'h1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        DEC,
    input  logic        QUE_OK,
    output logic [3:0]  STATE,
    output logic [23:0] QUESTION,
    output logic        CLR,
    output logic [3:0]  TIME_TENS,
    output logic [3:0]  TIME_ONES,
    output logic [3:0]  SCORE,
    output logic [3:0]  Q_NUM,
    output logic        LED_OK,
    output logic        LED_NG
);
    import game_pkg::*;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
    localparam logic [3:0] LIM_TENS = 4'(TIME_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(TIME_LIMIT % 10);

    state_t        state, next_state;
    logic [23:0]   question;
    logic          clr;
    logic [3:0]    score;
    logic [3:0]    q_num;
    logic          led_ok, led_ng;
    logic [3:0]    lfsr;
    logic [PW-1:0] prescaler;
    logic [HW-1:0] hold;
    logic          presc_wrap, tick, timer_zero, hold_done, last_q, in_result, start_ok;

    assign presc_wrap = (prescaler == PW'(TICK_DIV - 1));
    assign tick       = (state == ST_INPUT) && presc_wrap;
    assign hold_done  = (hold == HW'(RESULT_HOLD - 1));
    assign last_q     = (q_num == 4'(NUM_Q));
    assign in_result  = (state == ST_CORRECT) || (state == ST_WRONG) || (state == ST_TIMEOUT);
    assign start_ok   = START && ((state == ST_IDLE) || (state == ST_FINISH));

    bcd_down_timer u_timer (
        .clk       (CLK),
        .rst       (RST),
        .load      (state == ST_LOAD),
        .load_tens (LIM_TENS),
        .load_ones (LIM_ONES),
        .tick      (tick),
        .tens      (TIME_TENS),
        .ones      (TIME_ONES),
        .zero      (timer_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_FINISH: if (START) next_state = ST_LOAD;
            ST_LOAD:            next_state = ST_INPUT;
            // A decide press outranks the final timer tick landing in the same cycle.
            ST_INPUT: begin
                if (DEC)
                    next_state = ST_JUDGE;
                else if (timer_zero)
                    next_state = ST_TIMEOUT;
            end
            ST_JUDGE:           next_state = QUE_OK ? ST_CORRECT : ST_WRONG;
            ST_CORRECT, ST_WRONG, ST_TIMEOUT: begin
                if (hold_done)
                    next_state = last_q ? ST_FINISH : ST_LOAD;
            end
            default:            next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            question  <= 24'h000000;
            clr       <= 1'b0;
            score     <= 4'd0;
            q_num     <= 4'd0;
            led_ok    <= 1'b0;
            led_ng    <= 1'b0;
            lfsr      <= LFSR_SEED;
            prescaler <= '0;
            hold      <= '0;
        end else begin
            clr    <= (next_state == ST_LOAD);
            led_ok <= (next_state == ST_CORRECT);
            led_ng <= (next_state == ST_WRONG) || (next_state == ST_TIMEOUT);

            if (start_ok) begin
                score <= 4'd0;
                q_num <= 4'd0;
            end

            if (state == ST_LOAD) begin
                question  <= q_rom(lfsr);
                lfsr      <= lfsr_next(lfsr);
                q_num     <= q_num + 4'd1;
                prescaler <= '0;
            end else if (state == ST_INPUT) begin
                prescaler <= presc_wrap ? '0 : prescaler + 1'b1;
            end

            if ((state == ST_JUDGE) && QUE_OK)
                score <= bcd_inc_sat(score);

            if (in_result)
                hold <= hold_done ? '0 : hold + 1'b1;
            else
                hold <= '0;
        end
    end

    assign STATE    = state;
    assign QUESTION = question;
    assign CLR      = clr;
    assign SCORE    = score;
    assign Q_NUM    = q_num;
    assign LED_OK   = led_ok;
    assign LED_NG   = led_ng;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short timer/hold parameters.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, dec, que_ok;
    logic [3:0]  state;
    logic [23:0] question;
    logic        clr;
    logic [3:0]  time_tens, time_ones, score, q_num;
    logic        led_ok, led_ng;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    game_sequencer #(
        .TICK_DIV    (4),
        .TIME_LIMIT  (3),
        .RESULT_HOLD (2),
        .NUM_Q       (2),
        .LFSR_SEED   (4'h1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .DEC       (dec),
        .QUE_OK    (que_ok),
        .STATE     (state),
        .QUESTION  (question),
        .CLR       (clr),
        .TIME_TENS (time_tens),
        .TIME_ONES (time_ones),
        .SCORE     (score),
        .Q_NUM     (q_num),
        .LED_OK    (led_ok),
        .LED_NG    (led_ng)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dec = 1'b0; que_ok = 1'b0;
        step();
        step();
        check("rst_state", state, 0);
        check("rst_question", question, 0);
        check("rst_score", score, 0);
        check("rst_qnum", q_num, 0);
        check("rst_leds", {led_ok, led_ng}, 0);
        check("rst_clr", clr, 0);
        check("rst_time", {time_tens, time_ones}, 8'h00);
        rst = 1'b0;

        // DEC in IDLE does nothing
        dec = 1'b1; step(); dec = 1'b0;
        check("idle_dec", state, 0);

        // Game 1, question 1: correct answer
        start = 1'b1; step(); start = 1'b0;
        check("load_state", state, 1);
        check("load_clr", clr, 1);
        step();
        check("input_state", state, 2);
        check("input_clr", clr, 0);
        check("q1_question", question, 24'h000221);
        check("q1_time", {time_tens, time_ones}, 8'h03);
        check("q1_qnum", q_num, 1);
        start = 1'b1; step(); start = 1'b0;
        check("start_in_input", state, 2);
        dec = 1'b1; step(); dec = 1'b0;
        check("judge_state", state, 3);
        que_ok = 1'b1; step(); que_ok = 1'b0;
        check("correct_state", state, 4);
        check("correct_led", {led_ok, led_ng}, 2'b10);
        check("correct_score", score, 1);
        step();
        check("correct_hold2", state, 4);
        check("correct_led2", led_ok, 1);
        step();
        check("q2_load", state, 1);
        check("q2_clr", clr, 1);
        check("q2_led_off", led_ok, 0);
        step();
        check("q2_question", question, 24'h000323);
        check("q2_qnum", q_num, 2);
        check("q2_time", {time_tens, time_ones}, 8'h03);

        // Question 2: timeout, one BCD step every 4 cycles
        for (int i = 1; i <= 12; i++) begin
            step();
            check("timeout_time", {time_tens, time_ones}, 32'(3 - i / 4));
            check("timeout_state", state, (i == 12) ? 6 : 2);
        end
        check("timeout_led", {led_ok, led_ng}, 2'b01);
        step();
        check("timeout_hold2", state, 6);
        check("timeout_led2", led_ng, 1);
        step();
        check("finish_state", state, 7);
        check("finish_led", {led_ok, led_ng}, 0);
        check("finish_score", score, 1);
        check("finish_qnum", q_num, 2);
        step();
        check("finish_held", state, 7);

        // Game 2: new game from FINISH
        start = 1'b1; step(); start = 1'b0;
        check("g2_load", state, 1);
        check("g2_score_clr", score, 0);
        check("g2_qnum_clr", q_num, 0);
        step();
        check("g2_qnum", q_num, 1);
        check("g2_question", question, 24'h000437);

        // DEC lands on the same edge as the 01->00 tick
        for (int i = 0; i < 11; i++) step();
        check("edge_pre_time", {time_tens, time_ones}, 8'h01);
        check("edge_pre_state", state, 2);
        dec = 1'b1; step(); dec = 1'b0;
        check("edge_judge", state, 3);
        check("edge_time", {time_tens, time_ones}, 8'h00);
        que_ok = 1'b0; step();
        check("wrong_state", state, 5);
        check("wrong_led", {led_ok, led_ng}, 2'b01);
        check("wrong_score", score, 0);
        step();
        check("wrong_hold2", state, 5);
        step();
        check("g2q2_load", state, 1);
        step();
        check("g2q2_question", question, 24'h000667);
        check("g2q2_qnum", q_num, 2);
        dec = 1'b1; step(); dec = 1'b0;
        que_ok = 1'b1; step(); que_ok = 1'b0;
        check("g2q2_correct", state, 4);
        check("g2q2_score", score, 1);

        // Reset in the middle of a result display
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_state", state, 0);
        check("midrst_leds", {led_ok, led_ng}, 0);
        check("midrst_score", score, 0);
        check("midrst_qnum", q_num, 0);
        start = 1'b1; step(); start = 1'b0;
        step();
        check("reseed_question", question, 24'h000221);
        check("reseed_qnum", q_num, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
